popcount_sched: RTL and testbench
=================================

# popcount_sched

Shares one combinational `popcount` datapath between `NumReq` streaming requesters. A requester wins the unit and holds it for one frame, a multi-beat burst ending in `last`. The block accumulates the per-beat ones-count over the frame and returns the frame total, tagged with the requester ID, through a single-entry output register with a valid/ready handshake. It sits in front of bit-statistics consumers, such as mask and occupancy counters, that cannot each afford a private wide adder tree.

## Interface
- `NumReq`, default 4: number of requesters, ≥1.
- `DataWidth`, default 64: beat width fed to `popcount`, ≥1.
- `AccWidth`, default 16: frame-total width; must be ≥ $clog2(DataWidth)+1.
- `IdWidth`, default max(1,$clog2(NumReq)): requester ID width, derived; do not override.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  NumReq  beat valid per requester.
- `req_ready_o`  out  NumReq  beat accepted per requester.
- `req_data_i`  in  NumReq×DataWidth  beat data.
- `req_last_i`  in  NumReq  beat is final of frame.
- `clear_i`  in  1  synchronous abort of the in-progress frame.
- `res_valid_o`  out  1  frame result valid.
- `res_ready_i`  in  1  consumer accepts result.
- `res_count_o`  out  AccWidth  frame ones-count, saturated.
- `res_id_o`  out  IdWidth  requester that produced the result.
- `res_ovf_o`  out  1  count saturated during frame.
- `busy_o`  out  1  high in LOCK.

## Operation
- **FSM states.**
  - IDLE: no owner. Combinational round-robin over `req_valid_i`, starting at `rr_ptr`; the winner gets `req_ready_o` the same cycle.
  - LOCK: owner held in `grant_q`. Only `req_ready_o[grant_q]` may be high.
- **Beat acceptance.** A beat is accepted when valid && ready.
  - A non-last beat is always acceptable.
  - A last beat is acceptable only if `!res_valid_o || res_ready_i`.
- **Accumulation.**
  - `acc_d = acc_q + popcount(beat)`, computed at AccWidth+1 bits.
  - If the sum exceeds 2^AccWidth−1, clamp to 2^AccWidth−1 and set the sticky `ovf_q`.
- **Transitions.**
  - IDLE, non-last accepted → LOCK; `grant_q` = winner; `acc_q` = count.
  - IDLE, last accepted (single-beat frame) → stays IDLE; result loaded.
  - LOCK, last accepted → IDLE; result loaded.
- **Result load.** `res_count_o` = saturated total, `res_id_o` = owner, `res_ovf_o` = `ovf_q` OR this beat's overflow, `res_valid_o` = 1. Then `acc_q`/`ovf_q` ← 0 and `rr_ptr` ← (owner+1) mod NumReq.
- **Result handshake.** `res_valid_o` falls after a cycle with `res_ready_i` high, unless a new result loads that same cycle.
- **clear_i.**
  - Forces IDLE and zeros `acc_q`/`ovf_q`; all `req_ready_o` are low that cycle.
  - The output register is untouched and `rr_ptr` is unchanged.
  - clear_i has priority over any beat.
- **Requester protocol.** Once `req_valid_i` is raised, the requester holds it and its data/last stable until accepted. A violation is a protocol error, checked by an assertion.
- **Reset values.** While `rst_i` is high:
  - `req_ready_o` = 0, `res_valid_o` = 0, `res_count_o` = 0, `res_id_o` = 0, `res_ovf_o` = 0, `busy_o` = 0.
  - State IDLE, `rr_ptr` = 0.
- **Reset mid-frame.** Discards the partial frame and any pending result.

## Timing
- The popcount is combinational in the beat's accept cycle. The result appears on `res_*` the cycle after the last beat is accepted: latency 1.
- Throughput:
  - One beat per cycle.
  - Frames from different requesters run back-to-back with no bubble, because IDLE arbitration is same-cycle.
  - Single-beat frames sustain 1/cycle while `res_ready_i` is held high.
- Stall: a last beat waits with ready low while the output register is full and not draining. Non-last beats of the owner keep flowing.
- NumReq=1: the arbiter degenerates to a constant grant; `res_id_o` = 0.

## Structure
- Package `popcount_sched_pkg` holds:
  - the state enum (`IDLE`, `LOCK`);
  - the helper function computing IdWidth.
- Round-robin arbitration is written inline; it is too small to be a separate module.
- One sub-module: a single instance of the team's `popcount` with INPUT_WIDTH=DataWidth, fed by the beat mux selected by the grant (the IDLE winner or `grant_q`). Zero-extend its output to AccWidth+1 before adding.

## Test plan
- **Single-beat frame.** Req0 sends one last beat 0xFF, DataWidth=64, `res_ready_i`=1 → next cycle `res_count_o`=8, `res_id_o`=0, `res_ovf_o`=0.
- **Multi-beat frame with contention.** Req2 sends 3 beats of all-ones 64-bit, last on beat 3, while req1 holds valid → req1 ready stays 0 throughout; result 192, id 2; req1 is granted the cycle after.
- **Round-robin fairness.** All 4 requesters send continuous single-beat frames → result IDs 0,1,2,3,0,… with no bubble.
- **Back-pressure.** `res_ready_i`=0 with a result held, and req0's last beat pending → req0 ready=0. Raise `res_ready_i` → the old result drains and the new one loads in the same cycle.
- **Saturation.** AccWidth=7, 3 all-ones beats of 64 bits → `res_count_o`=127, `res_ovf_o`=1.
- **Clear and reset.**
  - `clear_i` after 2 beats of req3 → FSM returns to IDLE; req3's subsequent new frame counts from 0.
  - `rst_i` pulse while `res_valid_o`=1 → all outputs return to 0 immediately.

Source files
------------

// File: rtl/popcount_sched_pkg.sv
// Shared types and helpers for the popcount scheduler: FSM state encoding
// and the derived requester-ID width.
package popcount_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/popcount_sched_chk.sv
// Requester-side protocol checks for popcount_sched: an unaccepted beat must
// stay valid and stable, and at most one requester is ready at a time.
module popcount_sched_chk #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 64
) (
    input logic                        clk,
    input logic                        rst,
    input logic [NumReq-1:0]           req_valid,
    input logic [NumReq-1:0]           req_ready,
    input logic [NumReq*DataWidth-1:0] req_data,
    input logic [NumReq-1:0]           req_last
);

    for (genvar i = 0; i < NumReq; i++) begin : g_req
        a_hold : assert property (@(posedge clk) disable iff (rst)
            (req_valid[i] && !req_ready[i]) |=>
                (req_valid[i] && $stable(req_data[i*DataWidth +: DataWidth]) && $stable(req_last[i])))
            else $error("requester %0d dropped or changed an unaccepted beat", i);
    end

    a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready))
        else $error("more than one requester ready");

endmodule

// File: rtl/popcount_sched_popcount.sv
// Combinational population count of one beat; the shared adder tree that
// every requester borrows through the scheduler.
module popcount_sched_popcount #(
    parameter int INPUT_WIDTH = 64
) (
    input  logic [INPUT_WIDTH-1:0]             data,
    output logic [$clog2(INPUT_WIDTH+1)-1:0]   count
);

    localparam int CountWidth = $clog2(INPUT_WIDTH + 1);

    // Sum every bit of the beat
    always_comb begin
        count = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            count = count + CountWidth'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_sched.sv
// Frame-level popcount scheduler: round-robin grants one requester per frame,
// accumulates per-beat ones-counts and returns a tagged, saturated total.
module popcount_sched
    import popcount_sched_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int DataWidth = 64,
    parameter int AccWidth  = 16,
    parameter int IdWidth   = id_width(NumReq)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]             req_last_i,
    input  logic                          clear_i,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [AccWidth-1:0]           res_count_o,
    output logic [IdWidth-1:0]            res_id_o,
    output logic                          res_ovf_o,
    output logic                          busy_o
);

    localparam int CntWidth = $clog2(DataWidth + 1);
    localparam logic [AccWidth:0] AccMax = {1'b0, {AccWidth{1'b1}}};

    state_e                 state_q, state_d;
    logic [IdWidth-1:0]     grant_q, rr_ptr, winner, sel, next_ptr;
    logic                   found, sel_valid, sel_last, have_owner, last_ok;
    logic                   ready_en, accept, accept_last, beat_ovf;
    logic [NumReq-1:0]      sel_onehot;
    logic [DataWidth-1:0]   beat;
    logic [CntWidth-1:0]    beat_cnt;
    logic [AccWidth:0]      sum;
    logic [AccWidth-1:0]    acc_q, sat;
    logic                   ovf_q;
    logic                   res_valid_q, res_ovf_q;
    logic [AccWidth-1:0]    res_count_q;
    logic [IdWidth-1:0]     res_id_q;

    // Round-robin pick: the valid requester at the smallest offset from rr_ptr
    always_comb begin
        int best_off;
        int off;
        logic take;
        best_off = NumReq;
        winner   = '0;
        found    = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            off      = (i - int'(rr_ptr) + NumReq) % NumReq;
            take     = req_valid_i[i] && (off < best_off);
            winner   = take ? IdWidth'(i) : winner;
            best_off = take ? off : best_off;
            found    = found | req_valid_i[i];
        end
    end

    assign sel = (state_q == LOCK) ? grant_q : winner;

    // Beat mux onto the shared popcount, steered by the current grant
    always_comb begin
        logic hit;
        beat       = '0;
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NumReq; i++) begin
            hit           = (sel == IdWidth'(i));
            beat          = hit ? req_data_i[i*DataWidth +: DataWidth] : beat;
            sel_valid     = hit ? req_valid_i[i] : sel_valid;
            sel_last      = hit ? req_last_i[i] : sel_last;
            sel_onehot[i] = hit;
        end
    end

    popcount_sched_popcount #(
        .INPUT_WIDTH (DataWidth)
    ) u_popcount (
        .data  (beat),
        .count (beat_cnt)
    );

    // A last beat may only be taken when the result slot is free or draining
    assign have_owner  = (state_q == LOCK) || found;
    assign last_ok     = !sel_last || !res_valid_q || res_ready_i;
    assign ready_en    = !rst_i && !clear_i && have_owner && last_ok;
    assign req_ready_o = ready_en ? sel_onehot : {NumReq{1'b0}};
    assign accept      = ready_en && sel_valid;
    assign accept_last = accept && sel_last;

    assign sum      = {1'b0, acc_q} + {{(AccWidth + 1 - CntWidth){1'b0}}, beat_cnt};
    assign beat_ovf = (sum > AccMax);
    assign sat      = beat_ovf ? AccMax[AccWidth-1:0] : sum[AccWidth-1:0];
    assign next_ptr = (sel == IdWidth'(NumReq - 1)) ? {IdWidth{1'b0}} : sel + IdWidth'(1);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (accept && !sel_last) ? LOCK : IDLE;
            LOCK:    state_d = (clear_i || accept_last) ? IDLE : LOCK;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame accumulator, owner and round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_q <= '0;
            rr_ptr  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clear_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept_last) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            rr_ptr <= next_ptr;
        end else if (accept) begin
            acc_q   <= sat;
            ovf_q   <= ovf_q | beat_ovf;
            grant_q <= sel;
        end
    end

    // Single-entry result register; a fresh load wins over a drain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_valid_q <= 1'b0;
            res_count_q <= '0;
            res_id_q    <= '0;
            res_ovf_q   <= 1'b0;
        end else if (accept_last) begin
            res_valid_q <= 1'b1;
            res_count_q <= sat;
            res_id_q    <= sel;
            res_ovf_q   <= ovf_q | beat_ovf;
        end else if (res_ready_i) begin
            res_valid_q <= 1'b0;
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_count_o = res_count_q;
    assign res_id_o    = res_id_q;
    assign res_ovf_o   = res_ovf_q;
    assign busy_o      = (state_q == LOCK);

endmodule

// File: tb/tb_popcount_sched.sv
// Directed bench for popcount_sched: default instance for arbitration and
// handshake, a narrow-accumulator instance for saturation.
module tb_popcount_sched;

    localparam logic [63:0] ONES = '1;

    logic         clk, rst, clear, res_ready, res_valid, res_ovf, busy;
    logic [3:0]   req_valid, req_ready, req_last;
    logic [255:0] req_data;
    logic [15:0]  res_count;
    logic [1:0]   res_id;

    logic         s_res_ready, s_res_valid, s_res_ovf, s_busy;
    logic [3:0]   s_req_valid, s_req_ready, s_req_last;
    logic [255:0] s_req_data;
    logic [6:0]   s_res_count;
    logic [1:0]   s_res_id;

    int checks = 0;
    int errors = 0;
    int g;
    int prev_g;

    popcount_sched dut (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (req_valid), .req_ready_o (req_ready),
        .req_data_i (req_data), .req_last_i (req_last),
        .clear_i (clear),
        .res_valid_o (res_valid), .res_ready_i (res_ready),
        .res_count_o (res_count), .res_id_o (res_id),
        .res_ovf_o (res_ovf), .busy_o (busy)
    );

    popcount_sched #(.AccWidth(7)) dut_s (
        .clk_i (clk), .rst_i (rst),
        .req_valid_i (s_req_valid), .req_ready_o (s_req_ready),
        .req_data_i (s_req_data), .req_last_i (s_req_last),
        .clear_i (1'b0),
        .res_valid_o (s_res_valid), .res_ready_i (s_res_ready),
        .res_count_o (s_res_count), .res_id_o (s_res_id),
        .res_ovf_o (s_res_ovf), .busy_o (s_busy)
    );

    popcount_sched_chk chk_main (
        .clk (clk), .rst (rst), .req_valid (req_valid), .req_ready (req_ready),
        .req_data (req_data), .req_last (req_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; res_ready = 1'b0;
        req_valid = 4'd0; req_last = 4'd0; req_data = '0;
        s_res_ready = 1'b0; s_req_valid = 4'd0; s_req_last = 4'd0; s_req_data = '0;

        // reset state
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_count", 32'(res_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        next_cycle();
        rst = 1'b0;

        // single-beat frame from req0
        res_ready = 1'b1;
        req_valid = 4'b0001; req_last = 4'b0001; req_data[0 +: 64] = 64'hFF;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 4'd0; req_last = 4'd0;
        @(negedge clk);
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_count", 32'(res_count), 32'd8);
        chk("t1_id", 32'(res_id), 32'd0);
        chk("t1_ovf", 32'(res_ovf), 32'd0);

        // three-beat frame from req2 while req1 waits
        next_cycle();
        req_valid = 4'b0100; req_last = 4'b0000; req_data[128 +: 64] = ONES;
        @(negedge clk);
        chk("t2_ready_b1", 32'(req_ready), 32'h4);
        next_cycle();
        req_valid = 4'b0110; req_last = 4'b0010; req_data[64 +: 64] = 64'h3;
        @(negedge clk);
        chk("t2_ready_b2", 32'(req_ready), 32'h4);
        chk("t2_busy", 32'(busy), 32'd1);
        next_cycle();
        req_last = 4'b0110;
        @(negedge clk);
        chk("t2_ready_b3", 32'(req_ready), 32'h4);
        next_cycle();
        req_valid = 4'b0010; req_last = 4'b0010;
        @(negedge clk);
        chk("t2_count", 32'(res_count), 32'd192);
        chk("t2_id", 32'(res_id), 32'd2);
        chk("t2_busy_after", 32'(busy), 32'd0);
        chk("t2_req1_granted", 32'(req_ready), 32'h2);
        next_cycle();
        req_valid = 4'd0; req_last = 4'd0;
        @(negedge clk);
        chk("t2_req1_count", 32'(res_count), 32'd2);
        chk("t2_req1_id", 32'(res_id), 32'd1);

        // continuous single-beat frames from all four; pointer now at 2
        next_cycle();
        req_valid = 4'b1111; req_last = 4'b1111;
        req_data[0 +: 64] = 64'h1; req_data[64 +: 64] = 64'h3;
        req_data[128 +: 64] = 64'h7; req_data[192 +: 64] = 64'hF;
        prev_g = 0;
        for (int k = 0; k < 8; k++) begin
            g = (2 + k) % 4;
            @(negedge clk);
            chk("t3_grant", 32'(req_ready), 32'(1 << g));
            if (k > 0) begin
                chk("t3_id", 32'(res_id), 32'(prev_g));
                chk("t3_count", 32'(res_count), 32'(prev_g + 1));
            end
            prev_g = g;
            next_cycle();
            if (k >= 4) begin
                req_valid[g] = 1'b0;
                req_last[g]  = 1'b0;
            end
        end
        res_ready = 1'b0;
        @(negedge clk);
        chk("t3_last_id", 32'(res_id), 32'd1);
        chk("t3_last_count", 32'(res_count), 32'd2);

        // back-pressure on req0's last beat
        next_cycle();
        req_valid = 4'b0001; req_last = 4'b0001; req_data[0 +: 64] = 64'hF0F0;
        @(negedge clk);
        chk("t4_stall_ready", 32'(req_ready), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("t4_stall_ready2", 32'(req_ready), 32'd0);
        chk("t4_held_valid", 32'(res_valid), 32'd1);
        chk("t4_held_id", 32'(res_id), 32'd1);
        next_cycle();
        res_ready = 1'b1;
        @(negedge clk);
        chk("t4_drain_ready", 32'(req_ready), 32'd1);
        next_cycle();
        req_valid = 4'd0; req_last = 4'd0;
        @(negedge clk);
        chk("t4_valid", 32'(res_valid), 32'd1);
        chk("t4_count", 32'(res_count), 32'd8);
        chk("t4_id", 32'(res_id), 32'd0);

        // clear after two beats of req3, then a fresh single-beat frame
        next_cycle();
        req_valid = 4'b1000; req_last = 4'b0000; req_data[192 +: 64] = ONES;
        @(negedge clk);
        chk("t5_ready_b1", 32'(req_ready), 32'h8);
        next_cycle();
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd1);
        next_cycle();
        clear = 1'b1; req_last = 4'b1000; req_data[192 +: 64] = 64'h0F;
        @(negedge clk);
        chk("t5_clear_ready", 32'(req_ready), 32'd0);
        next_cycle();
        clear = 1'b0;
        @(negedge clk);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_regrant", 32'(req_ready), 32'h8);
        next_cycle();
        req_valid = 4'd0; req_last = 4'd0; res_ready = 1'b0;
        @(negedge clk);
        chk("t5_count", 32'(res_count), 32'd4);
        chk("t5_id", 32'(res_id), 32'd3);
        chk("t5_ovf", 32'(res_ovf), 32'd0);

        // asynchronous reset while a result is held
        next_cycle();
        chk("t6_pre_valid", 32'(res_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_valid", 32'(res_valid), 32'd0);
        chk("t6_count", 32'(res_count), 32'd0);
        chk("t6_id", 32'(res_id), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        next_cycle();
        rst = 1'b0;

        // saturation on the 7-bit accumulator
        s_res_ready = 1'b1;
        s_req_valid = 4'b0001; s_req_last = 4'b0000; s_req_data[0 +: 64] = ONES;
        next_cycle();
        next_cycle();
        s_req_last = 4'b0001;
        @(negedge clk);
        chk("t7_ready", 32'(s_req_ready), 32'd1);
        next_cycle();
        s_req_valid = 4'd0; s_req_last = 4'd0;
        @(negedge clk);
        chk("t7_valid", 32'(s_res_valid), 32'd1);
        chk("t7_count", 32'(s_res_count), 32'd127);
        chk("t7_ovf", 32'(s_res_ovf), 32'd1);
        chk("t7_id", 32'(s_res_id), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
